// File: rtl/serial_adder_pkg.sv
// Shared constants for the bit-serial adder: default width, FSM encoding
// and a helper that sizes the bit counter.
package serial_adder_pkg;

    localparam int WIDTH_DEFAULT = 8;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    // Counter must index bits 0..w-1; never narrower than one bit.
    function automatic int cnt_width(input int w);
        int cw;
        cw = $clog2(w);
        if (cw < 1) begin
            cw = 1;
        end else begin
            cw = cw;
        end
        return cw;
    endfunction

endpackage : serial_adder_pkg

// File: rtl/serial_adder_fa_cell.sv
// One-bit full adder used by the serial datapath, purely combinational.
module fa_cell (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic s,
    output logic co
);

    assign s  = a ^ b ^ cin;
    assign co = (a & b) | (a & cin) | (b & cin);

endmodule : fa_cell

// File: rtl/serial_adder.sv
// Bit-serial adder: one full-adder cell processes one operand bit per clock,
// LSB first; the final sum, carry and signed overflow are registered at once.
module serial_adder
    import serial_adder_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEFAULT
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);

    localparam int             CW   = cnt_width(WIDTH);
    localparam logic [CW-1:0]  LAST = CW'(WIDTH - 1);

    logic [1:0]       state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic             carry_q, carry_d;
    logic [WIDTH-1:0] res_q, res_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic             cout_q, cout_d;
    logic             ovf_q, ovf_d;
    logic             busy_q, done_q;
    logic             fa_s, fa_co;

    fa_cell u_fa (
        .a   (a_q[0]),
        .b   (b_q[0]),
        .cin (carry_q),
        .s   (fa_s),
        .co  (fa_co)
    );

    // Next-state and datapath update for the three-state sequencer
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        a_d     = a_q;
        b_d     = b_q;
        carry_d = carry_q;
        res_d   = res_q;
        sum_d   = sum_q;
        cout_d  = cout_q;
        ovf_d   = ovf_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    a_d     = a;
                    b_d     = b;
                    carry_d = cin;
                    cnt_d   = '0;
                    state_d = ST_RUN;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_RUN: begin
                a_d     = {1'b0, a_q[WIDTH-1:1]};
                b_d     = {1'b0, b_q[WIDTH-1:1]};
                res_d   = {fa_s, res_q[WIDTH-1:1]};
                carry_d = fa_co;
                cnt_d   = cnt_q + CW'(1);
                if (cnt_q == LAST) begin
                    // carry_q here is the carry into the MSB
                    sum_d   = {fa_s, res_q[WIDTH-1:1]};
                    cout_d  = fa_co;
                    ovf_d   = carry_q ^ fa_co;
                    state_d = ST_DONE;
                end else begin
                    state_d = ST_RUN;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State, datapath and registered status outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            carry_q <= 1'b0;
            res_q   <= '0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            a_q     <= a_d;
            b_q     <= b_d;
            carry_q <= carry_d;
            res_q   <= res_d;
            sum_q   <= sum_d;
            cout_q  <= cout_d;
            ovf_q   <= ovf_d;
            busy_q  <= (state_d != ST_IDLE);
            done_q  <= (state_d == ST_DONE);
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign sum  = sum_q;
    assign cout = cout_q;
    assign ovf  = ovf_q;

endmodule : serial_adder

// File: tb/tb_serial_adder.sv
// Directed and random checks of the 8-bit serial adder against hand-computed
// values and an a+b+cin reference.
module tb_serial_adder;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic [W-1:0] a, b;
    logic         cin;
    logic         busy, done, cout, ovf;
    logic [W-1:0] sum;

    int n_cmp = 0;
    int n_err = 0;

    serial_adder #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .a     (a),
        .b     (b),
        .cin   (cin),
        .busy  (busy),
        .done  (done),
        .sum   (sum),
        .cout  (cout),
        .ovf   (ovf)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Count cycles until done is seen, bounded so a dead DUT cannot hang us.
    task automatic wait_done(output int cyc);
        cyc = 0;
        while (!done && cyc < 40) begin
            tick();
            cyc++;
        end
    endtask

    task automatic run_op(input string tag, input logic [7:0] ia, input logic [7:0] ib,
                          input logic icin, input logic [7:0] esum,
                          input logic ecout, input logic eovf);
        int cyc;
        a = ia; b = ib; cin = icin; start = 1'b1;
        tick();
        start = 1'b0;
        check({tag, "_busy"}, 32'(busy), 32'd1);
        wait_done(cyc);
        check({tag, "_lat"}, 32'(cyc), 32'd8);
        check({tag, "_sum"}, 32'(sum), 32'(esum));
        check({tag, "_cout"}, 32'(cout), 32'(ecout));
        check({tag, "_ovf"}, 32'(ovf), 32'(eovf));
        tick();
        check({tag, "_done1"}, 32'(done), 32'd0);
        check({tag, "_idle"}, 32'(busy), 32'd0);
    endtask

    initial begin
        int cyc, ndone;
        logic [8:0] full;
        logic [7:0] ra, rb, es;
        logic       rc, eo;

        rst = 1'b1; start = 1'b0; a = 8'h00; b = 8'h00; cin = 1'b0;
        #12;
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_sum",  32'(sum),  32'd0);
        check("rst_cout", 32'(cout), 32'd0);
        check("rst_ovf",  32'(ovf),  32'd0);
        tick();
        rst = 1'b0;
        tick();

        run_op("d05_03", 8'h05, 8'h03, 1'b0, 8'h08, 1'b0, 1'b0);
        run_op("dff_01", 8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0);
        run_op("d00_c1", 8'h00, 8'h00, 1'b1, 8'h01, 1'b0, 1'b0);
        run_op("d7f_01", 8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1);
        run_op("d80_80", 8'h80, 8'h80, 1'b0, 8'h00, 1'b1, 1'b1);

        // Results hold while idle even with new operand values present
        a = 8'hAA; b = 8'h55; cin = 1'b1;
        repeat (5) tick();
        check("hold_sum",  32'(sum),  32'h00);
        check("hold_cout", 32'(cout), 32'd1);
        check("hold_ovf",  32'(ovf),  32'd1);

        // Restart attempt in the middle of a run is ignored
        a = 8'h05; b = 8'h03; cin = 1'b0; start = 1'b1;
        tick();
        start = 1'b0;
        tick(); tick();
        a = 8'h11; start = 1'b1;
        tick();
        start = 1'b0;
        wait_done(cyc);
        check("rs_lat", 32'(cyc + 3), 32'd8);
        check("rs_sum", 32'(sum), 32'h08);
        check("rs_busy_at_done", 32'(busy), 32'd1);
        ndone = 0;
        for (int i = 0; i < 12; i++) begin
            tick();
            if (done) ndone++;
            if (i == 0) check("rs_busy_after", 32'(busy), 32'd0);
        end
        check("rs_single_done", 32'(ndone), 32'd0);

        // Asynchronous reset between edges aborts the run
        a = 8'h33; b = 8'h44; cin = 1'b0; start = 1'b1;
        tick();
        start = 1'b0;
        repeat (3) tick();
        #3;
        rst = 1'b1;
        #1;
        check("ar_busy", 32'(busy), 32'd0);
        check("ar_sum",  32'(sum),  32'd0);
        check("ar_done", 32'(done), 32'd0);
        tick(); tick();
        rst = 1'b0;
        ndone = 0;
        for (int i = 0; i < 12; i++) begin
            tick();
            if (done || busy) ndone++;
        end
        check("ar_no_done", 32'(ndone), 32'd0);
        run_op("d0a_0a", 8'h0A, 8'h0A, 1'b0, 8'h14, 1'b0, 1'b0);

        // Start held high: one operation every WIDTH+2 cycles
        a = 8'h22; b = 8'h11; cin = 1'b0; start = 1'b1;
        wait_done(cyc);
        check("b2b_first_sum", 32'(sum), 32'h33);
        cyc = 0;
        do begin
            tick();
            cyc++;
        end while (!done && cyc < 40);
        check("b2b_period", 32'(cyc), 32'd10);
        start = 1'b0;
        repeat (3) tick();
        check("b2b_idle", 32'(busy), 32'd0);

        // Random sweep against the reference sum
        for (int i = 0; i < 1000; i++) begin
            ra = 8'($urandom_range(0, 255));
            rb = 8'($urandom_range(0, 255));
            rc = 1'($urandom_range(0, 1));
            full = {1'b0, ra} + {1'b0, rb} + {8'h00, rc};
            es = full[7:0];
            eo = (ra[7] == rb[7]) && (es[7] != ra[7]);
            run_op("rnd", ra, rb, rc, es, full[8], eo);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule : tb_serial_adder
